// File: rtl/control_switch_debounce.sv
// Purpose: sync, debounce and edge-detect the EDSAC Control Switch buttons; stop beats start/resume.
// Latency: DEBOUNCE_CYCLES+2 clocks from a clean raw edge to level/pulse. No backpressure; pulses are fire-and-forget.
// Optional: define CTRL_AUTOREPEAT_EN to make a held single_ep repeat every REPEAT_CYCLES.
module control_switch_debounce #(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 2500,
  parameter int CNT_W           = 12,
  parameter int ACTIVE_LOW      = 0,
  parameter int REPEAT_CYCLES   = 50000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse
);

  localparam int B_RESUME    = 0;
  localparam int B_SINGLE_EP = 1;
  localparam int B_START     = 2;
  localparam int B_STOP      = 3;

  localparam logic REL_LVL = (ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_EXIT = CNT_W'(DEBOUNCE_CYCLES - 2);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

  logic [N_BTN-1:0] sync1_q, sync2_q;
  logic [N_BTN-1:0] p;
  logic [N_BTN-1:0] raw_pulse;
  logic [N_BTN-1:0] arb_pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= {N_BTN{REL_LVL}};
      sync2_q <= {N_BTN{REL_LVL}};
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  assign p = sync2_q ^ {N_BTN{REL_LVL}};

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lvl_q, lvl_d;
    logic             pls;
    logic             rpt_pls;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        lvl_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        lvl_q   <= lvl_d;
      end
    end

    // Leaving a wait state happens on the cycle the count would reach its last value,
    // so the accepted change lands exactly DEBOUNCE_CYCLES+2 edges after the raw edge.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lvl_d   = lvl_q;
      pls     = 1'b0;
      case (state_q)
        IDLE: begin
          if (p[i]) begin
            state_d = PRESS_WAIT;
            cnt_d   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!p[i]) begin
            state_d = IDLE;
          end else if (cnt_q == CNT_EXIT) begin
            state_d = PRESSED;
            cnt_d   = CNT_LAST;
            lvl_d   = 1'b1;
            pls     = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PRESSED: begin
          if (!p[i]) begin
            state_d = RELEASE_WAIT;
            cnt_d   = '0;
          end
        end
        RELEASE_WAIT: begin
          if (p[i]) begin
            state_d = PRESSED;
          end else if (cnt_q == CNT_EXIT) begin
            state_d = IDLE;
            cnt_d   = CNT_LAST;
            lvl_d   = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

`ifdef CTRL_AUTOREPEAT_EN
    if (i == B_SINGLE_EP) begin : g_rpt
      localparam int RPT_W = $clog2(REPEAT_CYCLES + 1);
      localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
      logic [RPT_W-1:0] rpt_q;
      logic             held;

      assign held = (state_q == PRESSED) && p[i];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rpt_q <= '0;
        end else if (held) begin
          rpt_q <= (rpt_q == RPT_LAST) ? '0 : rpt_q + 1'b1;
        end else begin
          rpt_q <= '0;
        end
      end

      assign rpt_pls = held && (rpt_q == RPT_LAST);
    end else begin : g_norpt
      assign rpt_pls = 1'b0;
    end
`else
    assign rpt_pls = 1'b0;
`endif

    assign raw_pulse[i] = pls | rpt_pls;
    assign btn_level[i] = lvl_q;
  end

  // Stop wins over start/resume in the same cycle; levels are never touched.
  always_comb begin
    arb_pulse = raw_pulse;
    if (raw_pulse[B_STOP]) begin
      arb_pulse[B_START]  = 1'b0;
      arb_pulse[B_RESUME] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_pulse <= '0;
    end else begin
      btn_pulse <= arb_pulse;
    end
  end

endmodule

// File: tb/tb_control_switch_debounce.sv
// Directed bench for control_switch_debounce: an active-high and an active-low instance,
// expected outputs queued per instance at stimulus time and checked every cycle.
module tb_control_switch_debounce;

  typedef struct {
    int         cyc;
    logic [4:0] pulse;
    logic [4:0] level;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [4:0] raw0, raw1;
  logic [4:0] level0, level1;
  logic [4:0] pulse0, pulse1;

  exp_t q0[$];
  exp_t q1[$];
  logic [4:0] exp_lvl0, exp_lvl1;
  int cyc;
  int n_assert;
  int n_fail;

  control_switch_debounce #(
    .N_BTN(5), .DEBOUNCE_CYCLES(4), .CNT_W(12), .ACTIVE_LOW(0), .REPEAT_CYCLES(8)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .btn_raw(raw0), .btn_level(level0), .btn_pulse(pulse0)
  );

  control_switch_debounce #(
    .N_BTN(5), .DEBOUNCE_CYCLES(4), .CNT_W(12), .ACTIVE_LOW(1), .REPEAT_CYCLES(8)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .btn_raw(raw1), .btn_level(level1), .btn_pulse(pulse1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
    end
  endtask

  task automatic push0(input int off, input logic [4:0] pls, input logic [4:0] lvl);
    exp_t e;
    e.cyc = cyc + off; e.pulse = pls; e.level = lvl;
    q0.push_back(e);
  endtask

  task automatic push1(input int off, input logic [4:0] pls, input logic [4:0] lvl);
    exp_t e;
    e.cyc = cyc + off; e.pulse = pls; e.level = lvl;
    q1.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    logic [4:0] ep0, ep1;
    @(posedge clk);
    #1;
    cyc++;
    ep0 = 5'h00;
    ep1 = 5'h00;
    if (q0.size() > 0 && q0[0].cyc == cyc) begin
      e = q0.pop_front();
      ep0 = e.pulse;
      exp_lvl0 = e.level;
    end
    if (q1.size() > 0 && q1[0].cyc == cyc) begin
      e = q1.pop_front();
      ep1 = e.pulse;
      exp_lvl1 = e.level;
    end
    check("pulse_ah", pulse0, ep0);
    check("level_ah", level0, exp_lvl0);
    check("pulse_al", pulse1, ep1);
    check("level_al", level1, exp_lvl1);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    cyc      = 0;
    exp_lvl0 = 5'h00;
    exp_lvl1 = 5'h00;
    rst_n    = 1'b0;
    raw0     = 5'h1F;
    raw1     = 5'h1F;

    // Reset held with every active-high button pressed
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_pulse_ah", pulse0, 5'h00);
      check("rst_level_ah", level0, 5'h00);
      check("rst_pulse_al", pulse1, 5'h00);
      check("rst_level_al", level1, 5'h00);
    end
    rst_n = 1'b1;
    cyc   = 0;
    push0(6, 5'h1A, 5'h1F);
    repeat (8) tick();
    raw0 = 5'h00;
    push0(6, 5'h00, 5'h00);
    repeat (8) tick();

    // Clean start press and release
    raw0 = 5'h04;
    push0(6, 5'h04, 5'h04);
    repeat (8) tick();
    raw0 = 5'h00;
    push0(6, 5'h00, 5'h00);
    repeat (8) tick();

    // Resume bouncing, then steady
    raw0 = 5'h01; repeat (2) tick();
    raw0 = 5'h00; repeat (2) tick();
    raw0 = 5'h01; repeat (2) tick();
    raw0 = 5'h00; repeat (2) tick();
    raw0 = 5'h01;
    push0(6, 5'h01, 5'h01);
    repeat (8) tick();
    raw0 = 5'h00;
    push0(6, 5'h00, 5'h00);
    repeat (8) tick();

    // Start and stop together: stop wins the pulse, both levels rise
    raw0 = 5'h0C;
    push0(6, 5'h08, 5'h0C);
    repeat (8) tick();
    raw0 = 5'h00;
    push0(6, 5'h00, 5'h00);
    repeat (8) tick();

    // Active-low instance: resume pin low for 10 cycles
    raw1 = 5'h1E;
    push1(6, 5'h01, 5'h01);
    repeat (10) tick();
    raw1 = 5'h1F;
    push1(6, 5'h00, 5'h00);
    repeat (8) tick();

    // Single E.P. held 30 cycles
    raw0 = 5'h02;
    push0(6, 5'h02, 5'h02);
`ifdef CTRL_AUTOREPEAT_EN
    push0(14, 5'h02, 5'h02);
    push0(22, 5'h02, 5'h02);
    push0(30, 5'h02, 5'h02);
`endif
    repeat (30) tick();
    raw0 = 5'h00;
    push0(6, 5'h00, 5'h00);
    repeat (8) tick();

    check("queue_ah_drained", 5'(q0.size()), 5'h00);
    check("queue_al_drained", 5'(q1.size()), 5'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
